// File: rtl/drw_wrpack_if.sv
// drw_wrpack_if: pixel write stream in, burst command and data beats out.
interface drw_wrpack_if;
    logic        waddr_vld;
    logic [31:0] waddr;
    logic        wdata_vld;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        in_wready;
    logic        cmd_vld;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_rdy;
    logic        o_vld;
    logic [31:0] o_data;
    logic [3:0]  o_strb;
    logic        o_last;
    logic        o_rdy;
    logic        busy;
    modport master (
        output waddr_vld, waddr, wdata_vld, wdata, wstrb, wlast, cmd_rdy, o_rdy,
        input  in_wready, cmd_vld, cmd_addr, cmd_len, o_vld, o_data, o_strb, o_last, busy
    );
    modport slave (
        input  waddr_vld, waddr, wdata_vld, wdata, wstrb, wlast, cmd_rdy, o_rdy,
        output in_wready, cmd_vld, cmd_addr, cmd_len, o_vld, o_data, o_strb, o_last, busy
    );
endinterface

// File: rtl/drw_wrpack.sv
// drw_wrpack: packs contiguous single-beat pixel writes into INCR bursts, with one hold slot for a discontinuous beat.
module drw_wrpack #(
    parameter int MAXLEN  = 16,
    parameter int TIMEOUT = 8
) (
    input logic         clk,
    input logic         arst,
    input logic         rsts,
    drw_wrpack_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, CMD, DATA} state_t;
    state_t      state_q, state_d;
    logic [31:0] buf_data_q [MAXLEN];
    logic [3:0]  buf_strb_q [MAXLEN];
    logic [31:0] base_q, base_d, next_q, next_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  rdptr_q, rdptr_d;
    logic [7:0]  timer_q, timer_d;
    logic [31:0] hold_addr_q, hold_addr_d, hold_data_q, hold_data_d;
    logic [3:0]  hold_strb_q, hold_strb_d;
    logic        hold_last_q, hold_last_d, hold_v_q, hold_v_d;
    logic        wr_en;
    logic [3:0]  wr_idx, wr_strb;
    logic [31:0] wr_data;
    logic        rst_any, in_rdy, accept, contig, last_beat, cmd_vld, o_vld;

    // a burst ends on command end, full length, or when the next word would start a new 4 KB page
    function automatic logic closes(input logic [31:0] a, input logic last, input logic [4:0] n);
        logic [31:0] a4;
        a4 = a + 32'd4;
        return last | (n == 5'(MAXLEN)) | (a4[11:0] == 12'd0);
    endfunction

    assign rst_any   = arst | rsts;
    assign in_rdy    = (state_q == IDLE) | (state_q == FILL);
    assign accept    = in_rdy & bus.waddr_vld & bus.wdata_vld;
    assign contig    = bus.waddr == next_q;
    assign last_beat = {1'b0, rdptr_q} == count_q - 5'd1;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        next_d      = next_q;
        count_d     = count_q;
        rdptr_d     = rdptr_q;
        timer_d     = timer_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_strb_d = hold_strb_q;
        hold_last_d = hold_last_q;
        hold_v_d    = hold_v_q;
        wr_en       = 1'b0;
        wr_idx      = 4'd0;
        wr_data     = bus.wdata;
        wr_strb     = bus.wstrb;
        case (state_q)
            IDLE: if (accept) begin
                wr_en   = 1'b1;
                base_d  = bus.waddr;
                next_d  = bus.waddr + 32'd4;
                count_d = 5'd1;
                timer_d = 8'd0;
                state_d = closes(bus.waddr, bus.wlast, 5'd1) ? CMD : FILL;
            end
            FILL: if (accept && contig) begin
                wr_en   = 1'b1;
                wr_idx  = count_q[3:0];
                count_d = count_q + 5'd1;
                next_d  = next_q + 32'd4;
                timer_d = 8'd0;
                state_d = closes(bus.waddr, bus.wlast, count_q + 5'd1) ? CMD : FILL;
            end else if (accept) begin
                hold_addr_d = bus.waddr;
                hold_data_d = bus.wdata;
                hold_strb_d = bus.wstrb;
                hold_last_d = bus.wlast;
                hold_v_d    = 1'b1;
                state_d     = CMD;
            end else begin
                timer_d = timer_q + 8'd1;
                state_d = (timer_q == 8'(TIMEOUT - 1)) ? CMD : FILL;
            end
            CMD: if (bus.cmd_rdy) begin
                state_d = DATA;
                rdptr_d = 4'd0;
            end
            DATA: if (bus.o_rdy) begin
                rdptr_d = rdptr_q + 4'd1;
                // a held beat becomes the first beat of the next burst without passing through IDLE
                if (last_beat && hold_v_q) begin
                    wr_en    = 1'b1;
                    wr_data  = hold_data_q;
                    wr_strb  = hold_strb_q;
                    base_d   = hold_addr_q;
                    next_d   = hold_addr_q + 32'd4;
                    count_d  = 5'd1;
                    timer_d  = 8'd0;
                    hold_v_d = 1'b0;
                    state_d  = closes(hold_addr_q, hold_last_q, 5'd1) ? CMD : FILL;
                end else if (last_beat) begin
                    count_d = 5'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_any) begin
            state_q     <= IDLE;
            base_q      <= '0;
            next_q      <= '0;
            count_q     <= '0;
            rdptr_q     <= '0;
            timer_q     <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_strb_q <= '0;
            hold_last_q <= 1'b0;
            hold_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            next_q      <= next_d;
            count_q     <= count_d;
            rdptr_q     <= rdptr_d;
            timer_q     <= timer_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_strb_q <= hold_strb_d;
            hold_last_q <= hold_last_d;
            hold_v_q    <= hold_v_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_data_q[wr_idx] <= wr_data;
            buf_strb_q[wr_idx] <= wr_strb;
        end
    end

    assign cmd_vld       = ~rst_any & (state_q == CMD);
    assign o_vld         = ~rst_any & (state_q == DATA);
    assign bus.in_wready = ~rst_any & in_rdy;
    assign bus.cmd_vld   = cmd_vld;
    assign bus.cmd_addr  = cmd_vld ? base_q : '0;
    assign bus.cmd_len   = cmd_vld ? {3'd0, count_q - 5'd1} : '0;
    assign bus.o_vld     = o_vld;
    assign bus.o_data    = o_vld ? buf_data_q[rdptr_q] : '0;
    assign bus.o_strb    = o_vld ? buf_strb_q[rdptr_q] : '0;
    assign bus.o_last    = o_vld & last_beat;
    assign bus.busy      = ~rst_any & ((state_q != IDLE) | hold_v_q);
endmodule

// File: tb/tb_drw_wrpack.sv
// tb_drw_wrpack: vector table, multi-cycle timing sequences and a random backpressure scoreboard for drw_wrpack.
module tb_drw_wrpack;
    localparam int MAXLEN  = 16;
    localparam int TIMEOUT = 8;

    typedef struct { logic [31:0] addr; logic [7:0] len; int cyc; } cmd_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; int cyc; } beat_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic last; } in_t;
    typedef struct { logic [31:0] a; int n; int li; int nc; logic [31:0] a0; logic [7:0] l0; logic [31:0] a1; logic [7:0] l1; } vec_t;

    logic clk = 1'b0, arst = 1'b1, rsts = 1'b0;
    logic bp = 1'b0, busy_watch = 1'b0, busy_drop = 1'b0;
    int   cyc = 0, n_cmp = 0, n_bad = 0, last_acc = 0;
    cmd_t  cq[$], ecmd[$];
    beat_t bq[$], ebeat[$];
    in_t   inq[$];

    drw_wrpack_if b ();
    drw_wrpack #(.MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .arst(arst), .rsts(rsts), .bus(b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b.cmd_vld && b.cmd_rdy) cq.push_back('{b.cmd_addr, b.cmd_len, cyc});
        if (b.o_vld && b.o_rdy) bq.push_back('{b.o_data, b.o_strb, b.o_last, cyc});
        if (busy_watch && cq.size() < 2 && !b.busy) busy_drop = 1'b1;
    end

    initial begin
        b.cmd_rdy = 1'b1;
        b.o_rdy   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b.cmd_rdy = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
            b.o_rdy   = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic clr();
        cq.delete();
        bq.delete();
        inq.delete();
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        n = 0;
        b.waddr_vld = 1'b1; b.wdata_vld = 1'b1;
        b.waddr = a; b.wdata = d; b.wstrb = s; b.wlast = l;
        @(negedge clk);
        while (!b.in_wready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("put accept", 64'(n < 2000), 64'd1);
        last_acc = cyc;
        inq.push_back('{a, d, s, l});
        @(posedge clk);
        #1;
        b.waddr_vld = 1'b0; b.wdata_vld = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (b.busy && k < 20000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({nm, " drain"}, 64'(k < 20000), 64'd1);
    endtask

    // Expected bursts from the recorded input list: a burst runs until the beat that ends a command,
    // fills MAXLEN, ends a 4 KB page, is the last input, or is not followed by the next word address.
    task automatic build_model();
        int n;
        logic [31:0] st, a4;
        logic brk;
        n = 0;
        st = '0;
        ecmd.delete();
        ebeat.delete();
        for (int i = 0; i < inq.size(); i++) begin
            if (n == 0) st = inq[i].addr;
            n++;
            a4 = inq[i].addr + 32'd4;
            brk = inq[i].last || n == MAXLEN || a4[11:0] == 12'd0 || i == inq.size() - 1;
            if (!brk) brk = inq[i + 1].addr != a4;
            ebeat.push_back('{inq[i].data, inq[i].strb, brk, 0});
            if (brk) begin
                ecmd.push_back('{st, 8'(n - 1), 0});
                n = 0;
            end
        end
    endtask

    task automatic check_run(input string nm);
        drain(nm);
        build_model();
        chk({nm, " cmd count"}, 64'(cq.size()), 64'(ecmd.size()));
        for (int i = 0; i < ecmd.size() && i < cq.size(); i++) begin
            chk($sformatf("%s cmd%0d addr", nm, i), 64'(cq[i].addr), 64'(ecmd[i].addr));
            chk($sformatf("%s cmd%0d len", nm, i), 64'(cq[i].len), 64'(ecmd[i].len));
            chk($sformatf("%s cmd%0d maxlen", nm, i), 64'(cq[i].len < MAXLEN), 64'd1);
            chk($sformatf("%s cmd%0d page", nm, i), 64'(32'(cq[i].addr[11:0]) + 4 * 32'(cq[i].len) < 4096), 64'd1);
        end
        chk({nm, " beat count"}, 64'(bq.size()), 64'(ebeat.size()));
        for (int i = 0; i < ebeat.size() && i < bq.size(); i++)
            chk($sformatf("%s beat%0d", nm, i), {27'd0, bq[i].last, bq[i].strb, bq[i].data},
                {27'd0, ebeat[i].last, ebeat[i].strb, ebeat[i].data});
    endtask

    initial begin
        vec_t vt[7];
        logic [31:0] a, r;
        int t, a3, left, len;
        vt[0] = '{32'h1000_0000, 16, -1, 1, 32'h1000_0000, 8'd15, 32'h0, 8'd0};
        vt[1] = '{32'h0000_0FF8, 3, -1, 2, 32'h0000_0FF8, 8'd1, 32'h0000_1000, 8'd0};
        vt[2] = '{32'h0000_0200, 3, -1, 1, 32'h0000_0200, 8'd2, 32'h0, 8'd0};
        vt[3] = '{32'h0000_0300, 4, 1, 2, 32'h0000_0300, 8'd1, 32'h0000_0308, 8'd1};
        vt[4] = '{32'h0000_0400, 20, -1, 2, 32'h0000_0400, 8'd15, 32'h0000_0440, 8'd3};
        vt[5] = '{32'h0000_0FFC, 1, -1, 1, 32'h0000_0FFC, 8'd0, 32'h0, 8'd0};
        vt[6] = '{32'h2000_0FF0, 8, -1, 2, 32'h2000_0FF0, 8'd3, 32'h2000_1000, 8'd3};
        b.waddr_vld = 1'b0; b.wdata_vld = 1'b0; b.waddr = '0; b.wdata = '0; b.wstrb = '0; b.wlast = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctrl", {59'd0, b.in_wready, b.cmd_vld, b.o_vld, b.o_last, b.busy}, 64'd0);
        chk("reset cmd bus", {24'd0, b.cmd_len, b.cmd_addr}, 64'd0);
        chk("reset data bus", {28'd0, b.o_strb, b.o_data}, 64'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk);
        chk("ready after reset", {62'd0, b.in_wready, b.busy}, 64'd2);
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            clr();
            for (int k = 0; k < vt[v].n; k++) begin
                r = $urandom;
                put(vt[v].a + 32'(4 * k), r, r[7:4], k == vt[v].li);
            end
            check_run($sformatf("vec%0d", v));
            chk($sformatf("vec%0d ncmd", v), 64'(cq.size()), 64'(vt[v].nc));
            if (cq.size() > 0) chk($sformatf("vec%0d first", v), {cq[0].len, cq[0].addr}, {vt[v].l0, vt[v].a0});
            if (vt[v].nc > 1 && cq.size() > 1) chk($sformatf("vec%0d second", v), {cq[1].len, cq[1].addr}, {vt[v].l1, vt[v].a1});
        end

        clr();
        put(32'h100, 32'h1111_0001, 4'hF, 1'b0);
        busy_watch = 1'b1;
        busy_drop  = 1'b0;
        put(32'h104, 32'h1111_0002, 4'h3, 1'b0);
        put(32'h200, 32'h1111_0003, 4'h0, 1'b0);
        check_run("hold");
        busy_watch = 1'b0;
        chk("hold busy kept", 64'(busy_drop), 64'd0);
        if (cq.size() > 1) chk("hold bursts", {cq[0].len, cq[0].addr, cq[1].len}, {8'd1, 32'h100, 8'd0});

        clr();
        put(32'h500, 32'hA0, 4'hF, 1'b0);
        put(32'h504, 32'hA1, 4'hF, 1'b0);
        put(32'h508, 32'hA2, 4'hF, 1'b0);
        t = last_acc;
        check_run("timeout");
        if (cq.size() > 0) chk("timeout cmd cycle", 64'(cq[0].cyc), 64'(t + TIMEOUT + 1));
        if (bq.size() > 2) chk("timeout beat cycles", {32'(bq[0].cyc), 32'(bq[2].cyc)}, {32'(t + TIMEOUT + 2), 32'(t + TIMEOUT + 4)});

        clr();
        put(32'h600, 32'hB0, 4'h1, 1'b0);
        put(32'h604, 32'hB1, 4'h2, 1'b1);
        t = last_acc;
        put(32'h700, 32'hB2, 4'h4, 1'b0);
        a3 = last_acc;
        check_run("wlast");
        if (cq.size() > 0) chk("wlast cmd", {32'(cq[0].cyc), 24'd0, cq[0].len}, {32'(t + 1), 32'd1});
        if (bq.size() > 1) chk("wlast olast cycle", 64'(bq[1].cyc), 64'(t + 3));
        chk("ready after olast", 64'(a3), 64'(t + 4));

        clr();
        put(32'h800, 32'hC0, 4'h8, 1'b0);
        put(32'h900, 32'hC1, 4'h9, 1'b1);
        t = last_acc;
        check_run("hold close");
        if (cq.size() > 1) chk("hold close cycles", {32'(cq[0].cyc), 32'(cq[1].cyc)}, {32'(t + 1), 32'(t + 3)});
        if (bq.size() > 0) chk("hold close beat", 64'(bq[0].cyc), 64'(t + 2));

        clr();
        for (int k = 0; k < 10; k++) put(32'hA00 + 32'(4 * k), 32'hD000 + 32'(k), 4'hF, k == 9);
        t = 0;
        while (bq.size() < 4 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("rsts reached beat5", 64'(bq.size()), 64'd4);
        rsts = 1'b1;
        @(negedge clk);
        chk("rsts outputs", {59'd0, b.in_wready, b.cmd_vld, b.o_vld, b.o_last, b.busy}, 64'd0);
        @(posedge clk);
        #1;
        rsts = 1'b0;
        @(negedge clk);
        chk("after rsts", {60'd0, b.in_wready, b.cmd_vld, b.o_vld, b.busy}, 64'd8);
        chk("rsts no more beats", 64'(bq.size()), 64'd4);
        @(posedge clk);
        #1;
        clr();
        for (int k = 0; k < 5; k++) put(32'hB00 + 32'(4 * k), 32'hE000 + 32'(k), 4'(k), 1'b0);
        check_run("post rsts");

        bp = 1'b1;
        clr();
        left = 1000;
        while (left > 0) begin
            len = $urandom_range(1, 40);
            if (len > left) len = left;
            r = $urandom;
            a = ($urandom_range(0, 1) == 1) ? {r[31:12], 12'hF00} + 32'(4 * $urandom_range(0, 63)) : {r[31:2], 2'b00};
            for (int k = 0; k < len; k++) begin
                r = $urandom;
                put(a + 32'(4 * k), r, r[11:8], $urandom_range(0, 11) == 0);
            end
            left -= len;
        end
        check_run("random");
        bp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
